// File: rtl/race_sequencer_pkg.sv
// Shared encodings for the two-player race controller: FSM states, winner codes
// and BCD widths.
package race_pkg;
   localparam int BCD_W = 4;
   localparam logic [2*BCD_W-1:0] MAX_TIME_DEF = 8'h99;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CLEAR     = 3'd1,
      ST_COUNTDOWN = 3'd2,
      ST_RACE      = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_TIE  = 2'b11;
endpackage

// File: rtl/race_sequencer_rise_detect.sv
// Rising-edge detector: remembers last cycle's level so a held-high input
// produces exactly one pulse.
module rise_detect (
   input  logic clock,
   input  logic reset_n,
   input  logic level,
   output logic rise
);
   logic level_q_reg;

   always_ff @(posedge clock) begin
      if (!reset_n) level_q_reg <= 1'b0;
      else          level_q_reg <= level;
   end

   assign rise = level & ~level_q_reg;
endmodule

// File: rtl/race_sequencer.sv
// Race game controller: sequences divider/display counter through idle,
// countdown, race and done, tracks false starts, finish times and the winner.
module race_sequencer
   import race_pkg::*;
#(
   parameter int              COUNTDOWN_SECS = 3,
   parameter logic [7:0]      MAX_TIME       = MAX_TIME_DEF
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic               tick,
   input  logic               p1_done,
   input  logic               p2_done,
   input  logic [BCD_W-1:0]   time_ones,
   input  logic [BCD_W-1:0]   time_tens,
   output logic               div_enable,
   output logic               timer_clear,
   output logic               count_en,
   output logic [3:0]         countdown,
   output logic [2:0]         state,
   output logic [1:0]         false_start,
   output logic [7:0]         p1_time,
   output logic [7:0]         p2_time,
   output logic [1:0]         winner,
   output logic               race_over
);
   state_t     state_reg, state_next;
   logic [3:0] countdown_reg, countdown_next;
   logic [1:0] false_start_reg, false_start_next;
   logic [1:0] finished_reg, finished_next;
   logic [7:0] p1_time_reg, p1_time_next;
   logic [7:0] p2_time_reg, p2_time_next;
   logic [1:0] winner_reg, winner_next;
   logic       race_over_reg, race_over_next;
   logic       timer_clear_reg, timer_clear_next;
   logic       div_enable_reg, div_enable_next;

   logic       start_rise;
   logic       timeout;
   logic [7:0] race_time;
   logic [1:0] done_in;
   logic [1:0] finish_evt;

   rise_detect u_start_rise (
      .clock   (clock),
      .reset_n (reset_n),
      .level   (start),
      .rise    (start_rise)
   );

   assign race_time = {time_tens, time_ones};
   assign timeout   = (race_time == MAX_TIME);
   assign done_in   = {p2_done, p1_done};

   // A finish counts only once per player and never for a disqualified one.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_finish
         assign finish_evt[gi] = (state_reg == ST_RACE) & done_in[gi]
                                 & ~finished_reg[gi] & ~false_start_reg[gi];
      end
   endgenerate

   always_comb begin
      state_next       = state_reg;
      countdown_next   = countdown_reg;
      false_start_next = false_start_reg;
      finished_next    = finished_reg;
      p1_time_next     = p1_time_reg;
      p2_time_next     = p2_time_reg;
      winner_next      = winner_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start_rise) state_next = ST_CLEAR;
         end
         ST_CLEAR: begin
            state_next = (COUNTDOWN_SECS == 0) ? ST_RACE : ST_COUNTDOWN;
         end
         ST_COUNTDOWN: begin
            false_start_next = false_start_reg | done_in;
            if (tick) begin
               if (countdown_reg == 4'd1) begin
                  countdown_next = 4'd0;
                  state_next     = ST_RACE;
               end else begin
                  countdown_next = countdown_reg - 4'd1;
               end
            end
            if (false_start_next == 2'b11) begin
               winner_next = WIN_NONE;
               state_next  = ST_DONE;
            end
         end
         ST_RACE: begin
            finished_next = finished_reg | finish_evt;
            if (finish_evt[0]) p1_time_next = race_time;
            if (finish_evt[1]) p2_time_next = race_time;
            if ((finished_reg == 2'b00) && (finish_evt != 2'b00)) begin
               if (finish_evt == 2'b11)  winner_next = WIN_TIE;
               else if (finish_evt[0])   winner_next = WIN_P1;
               else                      winner_next = WIN_P2;
            end
            if (((finished_next | false_start_reg) == 2'b11) || (tick && timeout))
               state_next = ST_DONE;
         end
         ST_DONE: begin
            if (start_rise) state_next = ST_CLEAR;
         end
         default: state_next = ST_IDLE;
      endcase

      // Results are wiped on entry so the CLEAR cycle already shows a fresh race.
      if (state_next == ST_CLEAR) begin
         countdown_next   = 4'(COUNTDOWN_SECS);
         false_start_next = 2'b00;
         finished_next    = 2'b00;
         p1_time_next     = 8'h00;
         p2_time_next     = 8'h00;
         winner_next      = WIN_NONE;
      end

      timer_clear_next = (state_next == ST_CLEAR);
      race_over_next   = (state_next == ST_DONE);
      div_enable_next  = (state_next == ST_COUNTDOWN) || (state_next == ST_RACE);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg       <= ST_IDLE;
         countdown_reg   <= 4'd0;
         false_start_reg <= 2'b00;
         finished_reg    <= 2'b00;
         p1_time_reg     <= 8'h00;
         p2_time_reg     <= 8'h00;
         winner_reg      <= WIN_NONE;
         race_over_reg   <= 1'b0;
         timer_clear_reg <= 1'b0;
         div_enable_reg  <= 1'b0;
      end else begin
         state_reg       <= state_next;
         countdown_reg   <= countdown_next;
         false_start_reg <= false_start_next;
         finished_reg    <= finished_next;
         p1_time_reg     <= p1_time_next;
         p2_time_reg     <= p2_time_next;
         winner_reg      <= winner_next;
         race_over_reg   <= race_over_next;
         timer_clear_reg <= timer_clear_next;
         div_enable_reg  <= div_enable_next;
      end
   end

   assign count_en    = (state_reg == ST_RACE) & tick & ~timeout;
   assign state       = state_reg;
   assign countdown   = countdown_reg;
   assign false_start = false_start_reg;
   assign p1_time     = p1_time_reg;
   assign p2_time     = p2_time_reg;
   assign winner      = winner_reg;
   assign race_over   = race_over_reg;
   assign timer_clear = timer_clear_reg;
   assign div_enable  = div_enable_reg;
endmodule

// File: tb/tb_race_sequencer.sv
// Directed bench for race_sequencer: drives start/tick/done pulses and display
// digits, and checks every output against hand-computed values.
module tb_race_sequencer;
   logic       clock = 1'b0;
   logic       reset_n, start, tick, p1_done, p2_done;
   logic [3:0] time_ones, time_tens;
   logic       div_enable, timer_clear, count_en, race_over;
   logic [3:0] countdown;
   logic [2:0] state;
   logic [1:0] false_start, winner;
   logic [7:0] p1_time, p2_time;

   int n_checks = 0;
   int n_fail   = 0;

   race_sequencer dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .tick        (tick),
      .p1_done     (p1_done),
      .p2_done     (p2_done),
      .time_ones   (time_ones),
      .time_tens   (time_tens),
      .div_enable  (div_enable),
      .timer_clear (timer_clear),
      .count_en    (count_en),
      .countdown   (countdown),
      .state       (state),
      .false_start (false_start),
      .p1_time     (p1_time),
      .p2_time     (p2_time),
      .winner      (winner),
      .race_over   (race_over)
   );

   always #5 clock = ~clock;

   task automatic check_equal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s = %0h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_time(input logic [7:0] t);
      time_tens = t[7:4];
      time_ones = t[3:0];
   endtask

   task automatic tick_pulse();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic done_pulse(input logic d1, input logic d2);
      p1_done = d1;
      p2_done = d2;
      step();
      p1_done = 1'b0;
      p2_done = 1'b0;
   endtask

   // Drop then raise start, landing in COUNTDOWN with a freshly loaded count.
   task automatic restart(input string tag);
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      check_equal({tag, " clear state"}, 32'(state), 32'd1);
      check_equal({tag, " timer_clear"}, 32'(timer_clear), 32'd1);
      step();
      check_equal({tag, " countdown state"}, 32'(state), 32'd2);
      check_equal({tag, " countdown load"}, 32'(countdown), 32'd3);
   endtask

   task automatic count_to_race(input string tag);
      tick_pulse();
      tick_pulse();
      tick_pulse();
      check_equal({tag, " race state"}, 32'(state), 32'd3);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; tick = 1'b0;
      p1_done = 1'b0; p2_done = 1'b0;
      set_time(8'h00);
      step(); step();
      check_equal("reset state", 32'(state), 32'd0);
      check_equal("reset outputs", {14'd0, countdown, false_start, winner, race_over, div_enable,
                   timer_clear, count_en, 6'd0}, 32'd0);
      check_equal("reset times", {16'd0, p1_time, p2_time}, 32'd0);
      reset_n = 1'b1;
      step();
      check_equal("idle hold", 32'(state), 32'd0);

      // Normal race: P1 at 12 s, P2 at 15 s
      start = 1'b1;
      step();
      check_equal("r1 clear state", 32'(state), 32'd1);
      check_equal("r1 timer_clear", 32'(timer_clear), 32'd1);
      check_equal("r1 div_enable clear", 32'(div_enable), 32'd0);
      step();
      check_equal("r1 countdown=3", 32'(countdown), 32'd3);
      check_equal("r1 timer_clear off", 32'(timer_clear), 32'd0);
      check_equal("r1 div_enable", 32'(div_enable), 32'd1);
      tick_pulse();
      check_equal("r1 countdown=2", 32'(countdown), 32'd2);
      tick_pulse();
      check_equal("r1 countdown=1", 32'(countdown), 32'd1);
      check_equal("r1 still countdown", 32'(state), 32'd2);
      tick_pulse();
      check_equal("r1 race state", 32'(state), 32'd3);
      check_equal("r1 countdown=0", 32'(countdown), 32'd0);
      tick = 1'b1; #1;
      check_equal("r1 count_en tick", 32'(count_en), 32'd1);
      tick = 1'b0; #1;
      check_equal("r1 count_en idle", 32'(count_en), 32'd0);
      set_time(8'h12);
      done_pulse(1'b1, 1'b0);
      check_equal("r1 p1_time", 32'(p1_time), 32'h12);
      check_equal("r1 winner p1", 32'(winner), 32'd1);
      check_equal("r1 racing on", 32'(state), 32'd3);
      set_time(8'h15);
      done_pulse(1'b0, 1'b1);
      check_equal("r1 p2_time", 32'(p2_time), 32'h15);
      check_equal("r1 winner kept", 32'(winner), 32'd1);
      check_equal("r1 done state", 32'(state), 32'd4);
      check_equal("r1 race_over", 32'(race_over), 32'd1);
      check_equal("r1 div_enable off", 32'(div_enable), 32'd0);
      step(); step();
      check_equal("held start no retrigger", 32'(state), 32'd4);
      check_equal("held start results kept", 32'(p1_time), 32'h12);

      // Tie at 07 s
      restart("r2");
      check_equal("r2 times cleared", {16'd0, p1_time, p2_time}, 32'd0);
      check_equal("r2 race_over cleared", 32'(race_over), 32'd0);
      count_to_race("r2");
      set_time(8'h07);
      done_pulse(1'b1, 1'b1);
      check_equal("r2 p1_time", 32'(p1_time), 32'h07);
      check_equal("r2 p2_time", 32'(p2_time), 32'h07);
      check_equal("r2 winner tie", 32'(winner), 32'd3);
      check_equal("r2 done", 32'(state), 32'd4);

      // P2 false start, P1 finishes alone at 20 s
      restart("r3");
      done_pulse(1'b0, 1'b1);
      check_equal("r3 false_start", 32'(false_start), 32'b10);
      start = 1'b0; step(); start = 1'b1; step();
      check_equal("r3 start ignored", 32'(state), 32'd2);
      count_to_race("r3");
      set_time(8'h18);
      done_pulse(1'b0, 1'b1);
      check_equal("r3 dq p2 ignored", 32'(p2_time), 32'h00);
      check_equal("r3 dq winner none", 32'(winner), 32'd0);
      set_time(8'h20);
      done_pulse(1'b1, 1'b0);
      check_equal("r3 p1_time", 32'(p1_time), 32'h20);
      check_equal("r3 winner p1", 32'(winner), 32'd1);
      check_equal("r3 done", 32'(state), 32'd4);

      // Timeout at 99 with no finishers
      restart("r4");
      count_to_race("r4");
      set_time(8'h98);
      tick = 1'b1; #1;
      check_equal("r4 count_en at 98", 32'(count_en), 32'd1);
      step(); tick = 1'b0;
      check_equal("r4 still racing", 32'(state), 32'd3);
      set_time(8'h99);
      tick = 1'b1; #1;
      check_equal("r4 count_en at max", 32'(count_en), 32'd0);
      step(); tick = 1'b0;
      check_equal("r4 timeout done", 32'(state), 32'd4);
      check_equal("r4 winner none", 32'(winner), 32'd0);
      check_equal("r4 times zero", {16'd0, p1_time, p2_time}, 32'd0);

      // Both players false-start
      restart("r5");
      done_pulse(1'b1, 1'b1);
      check_equal("r5 double dq done", 32'(state), 32'd4);
      check_equal("r5 false_start", 32'(false_start), 32'b11);
      check_equal("r5 winner none", 32'(winner), 32'd0);

      // Reset in the middle of a race
      restart("r6");
      count_to_race("r6");
      set_time(8'h05);
      done_pulse(1'b1, 1'b0);
      check_equal("r6 p1_time", 32'(p1_time), 32'h05);
      reset_n = 1'b0;
      step();
      check_equal("r6 reset state", 32'(state), 32'd0);
      check_equal("r6 reset outputs", {14'd0, countdown, false_start, winner, race_over, div_enable,
                   timer_clear, count_en, 6'd0}, 32'd0);
      check_equal("r6 reset times", {16'd0, p1_time, p2_time}, 32'd0);
      reset_n = 1'b1;
      step();
      check_equal("r6 start_q cleared by reset", 32'(state), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/race_sequencer.md
Name: race_sequencer

Overview:
- Top-level game controller for the two-player race.
- Sequences the existing 1 Hz rate divider and two-digit BCD display counter through idle, pre-race countdown, race and finished phases.
- Detects false starts, latches each player's BCD finish time from the display counter and decides the winner.
- Sits between the board switches/keys and the rate-divider/display-counter/hex-decoder datapath.

Parameters:
COUNTDOWN_SECS, 3, pre-race countdown length in seconds (0..9; 0 = go straight to race)
MAX_TIME, 8'h99, BCD race time limit {tens,ones}; race ends on the tick at which elapsed time equals this value

Ports:
clock  in  1  system clock (CLOCK_50)
reset_n  in  1  synchronous active-low reset
start  in  1  start/restart level from switch; only a rising edge acts
tick  in  1  one-cycle pulse from 1 Hz rate divider (divider count == 0)
p1_done  in  1  one-cycle pulse: player 1 crossed line
p2_done  in  1  one-cycle pulse: player 2 crossed line
time_ones  in  4  BCD ones digit from display counter
time_tens  in  4  BCD tens digit from display counter
div_enable  out  1  enable to rate divider
timer_clear  out  1  one-cycle clear to rate divider and display counter (drive their reset_n low)
count_en  out  1  increment enable to display counter
countdown  out  4  BCD seconds remaining before go
state  out  3  current state encoding
false_start  out  2  bit0 = P1, bit1 = P2 disqualified
p1_time  out  8  latched BCD finish time P1
p2_time  out  8  latched BCD finish time P2
winner  out  2  00 none, 01 P1, 10 P2, 11 tie
race_over  out  1  high in DONE

Behaviour:
- Reset is reset_n, synchronous, active-low; clock is clock. Reset forces IDLE and clears every register output to 0: countdown, false_start, p1_time, p2_time, winner, race_over, internal start_q. This holds from any state, including mid-race.
- start_rise = start & ~start_q. start_q is registered every cycle. A held-high start never retriggers.
- States (state output): IDLE=0, CLEAR=1, COUNTDOWN=2, RACE=3, DONE=4.
- IDLE: div_enable=0, count_en=0. start_rise -> CLEAR.
- CLEAR:
  - Lasts exactly one cycle; timer_clear=1 (registered, asserted during this cycle only).
  - Loads countdown=COUNTDOWN_SECS and clears false_start, p1_time, p2_time, winner, race_over.
  - Next state is COUNTDOWN, or RACE if COUNTDOWN_SECS==0.
- COUNTDOWN:
  - div_enable=1, count_en=0.
  - On tick: if countdown==1, go to RACE with countdown=0; otherwise decrement countdown.
  - pN_done here sets false_start[N-1].
  - If both false-start bits are set -> DONE with winner=00.
- RACE:
  - div_enable=1. count_en = tick & ~timeout, combinational, where timeout = ({time_tens,time_ones}==MAX_TIME).
  - pN_done with player N not yet finished and not false-started: latch pN_time = {time_tens,time_ones} as sampled that cycle, and set finished_N.
  - winner is set only by the first finish event. Same-cycle finishes give 11 (tie). Later finishes do not change winner.
  - Done pulses from already finished or disqualified players are ignored.
  - Go to DONE when every non-disqualified player has finished, or on tick & timeout.
  - A finish on the same cycle as a timeout tick is recorded before the transition.
  - Unfinished players keep time 8'h00. If nobody finished, winner stays 00.
- DONE: div_enable=0, count_en=0, race_over=1; all results hold. start_rise -> CLEAR, which restarts the race.
- start_rise in COUNTDOWN or RACE is ignored.
- All register updates occur on posedge clock; the only combinational output is count_en.

Decomposition:
- Package race_pkg: state encodings, winner codes (WIN_NONE/WIN_P1/WIN_P2/WIN_TIE), BCD width constant (4), default MAX_TIME.
- One sub-module, rise_detect (registered rising-edge detector), used for start.
- The existing rate divider and display counter remain external.

Test Plan:
- Reset, then start rising edge -> CLEAR for 1 cycle with timer_clear=1; COUNTDOWN with countdown=3; after ticks 3->2->1, RACE on the third tick.
- RACE: p1_done at display 12 s, p2_done at 15 s -> p1_time=8'h12, p2_time=8'h15, winner=01, DONE with race_over=1, div_enable=0.
- p1_done and p2_done on the same cycle at 07 s -> both times 8'h07, winner=11.
- p2_done during COUNTDOWN -> false_start=10; p1_done at 20 s -> winner=01, immediate DONE.
- No finishes; display reaches 99 and a tick arrives -> count_en stays 0 on that tick, DONE, winner=00, times 00.
- start held high through DONE -> no restart; drop then raise -> CLEAR and results cleared. reset_n low mid-RACE -> IDLE, all outputs 0 next edge.
